// File: rtl/wired_bus_arbiter_if.sv
// Signal bundle between the bus arbiter (slave side) and the requesters that
// share the resolved net (master side).
interface wired_bus_arbiter_if #(
  parameter int N_REQ = 4
) ();
  localparam int OW = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [OW-1:0]    owner;
  logic             busy;
  logic             keeper_en;
  logic             timeout;

  modport master (
    output req,
    input  gnt, owner, busy, keeper_en, timeout
  );

  modport slave (
    input  req,
    output gnt, owner, busy, keeper_en, timeout
  );
endinterface

// File: rtl/wired_bus_arbiter.sv
// Round-robin arbiter for a shared resolved bus net: one driver at a time, a
// bounded hold time, and an undriven turnaround gap between successive owners.
module wired_bus_arbiter #(
  parameter int N_REQ      = 4,
  parameter int MAX_HOLD   = 8,
  parameter int TURNAROUND = 1
) (
  input logic                clk,
  input logic                rst_n,
  wired_bus_arbiter_if.slave bus
);
  localparam int OW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  localparam logic [OW:0]   N_C        = (OW+1)'(N_REQ);
  localparam logic [OW-1:0] LAST_C     = OW'(N_REQ - 1);
  localparam logic [HW-1:0] MAX_HOLD_C = HW'(MAX_HOLD);
  localparam logic [2:0]    TURN_C     = 3'(TURNAROUND);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [OW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [2:0]       turn_cnt_q, turn_cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic             busy_q, busy_d;
  logic             keeper_en_q, keeper_en_d;
  logic             timeout_q, timeout_d;

  logic             pick_found;
  logic [OW-1:0]    pick_idx;
  logic             owner_req;

  // Rotate the request vector so rr_ptr sits at bit 0, take the lowest set bit,
  // then map the offset back to an absolute requester index mod N_REQ.
  function automatic logic [OW:0] rr_pick(input logic [N_REQ-1:0] r,
                                          input logic [OW-1:0]    ptr);
    logic [2*N_REQ-1:0] rot;
    logic [OW:0]        off;
    logic [OW:0]        sum;
    logic               found;
    rot   = {r, r} >> ptr;
    found = 1'b0;
    off   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = (OW+1)'(i);
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= N_C) sum = sum - N_C;
    return {found, sum[OW-1:0]};
  endfunction

  assign {pick_found, pick_idx} = rr_pick(bus.req, rr_ptr_q);
  assign owner_req              = |(gnt_q & bus.req);

  // NOTE: every variable written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    turn_cnt_d = turn_cnt_q;
    gnt_d      = '0;
    owner_d    = owner_q;
    timeout_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = HOLD;
          gnt_d      = N_REQ'(1) << pick_idx;
          owner_d    = pick_idx;
          hold_cnt_d = HW'(1);
        end
      end

      HOLD: begin
        // A drop on the last allowed cycle counts as voluntary: no timeout.
        if (!owner_req || hold_cnt_q == MAX_HOLD_C) begin
          state_d    = TURN;
          timeout_d  = owner_req;
          rr_ptr_d   = (owner_q == LAST_C) ? '0 : owner_q + OW'(1);
          turn_cnt_d = 3'd1;
        end else begin
          gnt_d      = gnt_q;
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end

      TURN: begin
        if (turn_cnt_q < TURN_C) begin
          turn_cnt_d = turn_cnt_q + 3'd1;
        end else if (pick_found) begin
          state_d    = HOLD;
          gnt_d      = N_REQ'(1) << pick_idx;
          owner_d    = pick_idx;
          hold_cnt_d = HW'(1);
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    keeper_en_d = (gnt_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      hold_cnt_q  <= '0;
      turn_cnt_q  <= '0;
      gnt_q       <= '0;
      owner_q     <= '0;
      busy_q      <= 1'b0;
      keeper_en_q <= 1'b1;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      turn_cnt_q  <= turn_cnt_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      keeper_en_q <= keeper_en_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = busy_q;
  assign bus.keeper_en = keeper_en_q;
  assign bus.timeout   = timeout_q;

  // Two drivers on the resolved net would corrupt it; the keeper must track it.
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
  a_keeper_match: assert property (@(posedge clk) disable iff (!rst_n)
                                   keeper_en_q == (gnt_q == '0));
endmodule

// File: tb/tb_wired_bus_arbiter.sv
// Scoreboarded bench for wired_bus_arbiter: stimulus queues expected grant runs,
// a negedge monitor reconstructs actual runs and compares them as they finish.
module tb_wired_bus_arbiter;
  typedef struct {
    logic [3:0] gnt;
    int         len;
    logic       to;
    int         gap;    // -1: gap before this run is not checked
    int         owner;  // owner value on the cycle gnt drops
  } run_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  wired_bus_arbiter_if #(.N_REQ(4)) bus_a ();
  wired_bus_arbiter_if #(.N_REQ(4)) bus_b ();

  wired_bus_arbiter #(.N_REQ(4), .MAX_HOLD(8), .TURNAROUND(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  wired_bus_arbiter #(.N_REQ(4), .MAX_HOLD(4), .TURNAROUND(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  int   n_vec  = 0;
  int   n_miss = 0;
  run_t exp_q_a[$];
  run_t exp_q_b[$];

  logic [3:0] prev_gnt[2];
  int         run_len[2];
  int         zero_cnt[2];
  int         cur_gap[2];
  logic       gap_valid[2];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [3:0] g, input int len,
                      input logic to, input int gap, input int owner);
    run_t e;
    e.gnt = g; e.len = len; e.to = to; e.gap = gap; e.owner = owner;
    if (d == 0) exp_q_a.push_back(e);
    else        exp_q_b.push_back(e);
  endtask

  task automatic mon_step(input int d, input logic [3:0] g, input logic to,
                          input logic [1:0] own, input logic keep, input logic bsy);
    run_t e;
    logic has;
    logic [3:0] pg;
    pg = prev_gnt[d];
    check($sformatf("dut%0d invariants(onehot,keeper,busy)", d),
          int'($onehot0(g) && (keep == (g == 4'd0)) && (g == 4'd0 || bsy)), 1);
    check($sformatf("dut%0d timeout outside drop", d),
          int'(to && !(pg != 4'd0 && g == 4'd0)), 0);
    if (g != 4'd0 && pg == 4'd0) begin
      run_len[d] = 1;
      cur_gap[d] = gap_valid[d] ? zero_cnt[d] : -1;
    end else if (g != 4'd0) begin
      run_len[d]++;
    end else if (pg != 4'd0) begin
      has = (d == 0) ? (exp_q_a.size() > 0) : (exp_q_b.size() > 0);
      check($sformatf("dut%0d run expected", d), int'(has), 1);
      if (has) begin
        if (d == 0) e = exp_q_a.pop_front();
        else        e = exp_q_b.pop_front();
        check($sformatf("dut%0d run gnt", d), int'(pg), int'(e.gnt));
        check($sformatf("dut%0d run length", d), run_len[d], e.len);
        check($sformatf("dut%0d timeout at drop", d), int'(to), int'(e.to));
        check($sformatf("dut%0d owner at drop", d), int'(own), e.owner);
        if (e.gap >= 0) check($sformatf("dut%0d gap before run", d), cur_gap[d], e.gap);
      end
      gap_valid[d] = 1'b1;
      zero_cnt[d]  = 1;
    end else begin
      zero_cnt[d]++;
    end
    prev_gnt[d] = g;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      prev_gnt[i] = '0; run_len[i] = 0; zero_cnt[i] = 0;
      cur_gap[i] = -1; gap_valid[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    mon_step(0, bus_a.gnt, bus_a.timeout, bus_a.owner, bus_a.keeper_en, bus_a.busy);
    mon_step(1, bus_b.gnt, bus_b.timeout, bus_b.owner, bus_b.keeper_en, bus_b.busy);
    if (!rst_n) begin
      gap_valid[0] = 1'b0;
      gap_valid[1] = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 ns after an edge with reset released: "cycle 0".
  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_a.req = '0;
    bus_b.req = '0;

    // Single requester, voluntary release after 3 granted cycles.
    #2 rst_n = 1'b0;
    #1;
    check("reset gnt", int'(bus_a.gnt), 0);
    check("reset owner", int'(bus_a.owner), 0);
    check("reset busy", int'(bus_a.busy), 0);
    check("reset keeper_en", int'(bus_a.keeper_en), 1);
    check("reset timeout", int'(bus_a.timeout), 0);
    tick(2);
    rst_n = 1'b1;
    push(0, 4'b0001, 3, 1'b0, -1, 0);
    bus_a.req = 4'b0001;
    tick(3);
    bus_a.req = 4'b0000;
    tick(1);
    check("c4 keeper_en", int'(bus_a.keeper_en), 1);
    check("c4 busy", int'(bus_a.busy), 1);
    tick(1);
    check("c5 busy", int'(bus_a.busy), 0);
    tick(2);

    // All four requesting: forced releases in round-robin order 0,1,2,3,0.
    do_reset();
    push(0, 4'b0001, 8, 1'b1, -1, 0);
    push(0, 4'b0010, 8, 1'b1,  1, 1);
    push(0, 4'b0100, 8, 1'b1,  1, 2);
    push(0, 4'b1000, 8, 1'b1,  1, 3);
    push(0, 4'b0001, 8, 1'b1,  1, 0);
    bus_a.req = 4'b1111;
    tick(45);
    bus_a.req = 4'b0000;
    tick(3);

    // Lone requester 2 is re-granted after each forced release.
    push(0, 4'b0100, 8, 1'b1, -1, 2);
    push(0, 4'b0100, 8, 1'b1,  1, 2);
    push(0, 4'b0100, 8, 1'b1,  1, 2);
    push(0, 4'b0100, 3, 1'b0,  1, 2);
    bus_a.req = 4'b0100;
    tick(30);
    bus_a.req = 4'b0000;
    tick(3);

    // Requester 1 drops exactly at hold_cnt==MAX_HOLD: voluntary, then 3 wins.
    do_reset();
    push(0, 4'b0010, 8, 1'b0, -1, 1);
    push(0, 4'b1000, 3, 1'b0,  1, 3);
    bus_a.req = 4'b1010;
    tick(8);
    bus_a.req = 4'b1000;
    tick(4);
    bus_a.req = 4'b0000;
    tick(3);

    // Asynchronous reset in the middle of owner 2's hold (hold_cnt 5).
    do_reset();
    push(0, 4'b0100, 5, 1'b0, -1, 0);
    bus_a.req = 4'b0100;
    tick(5);
    #6 rst_n = 1'b0;
    #1;
    check("async reset gnt", int'(bus_a.gnt), 0);
    check("async reset keeper_en", int'(bus_a.keeper_en), 1);
    check("async reset owner", int'(bus_a.owner), 0);
    check("async reset busy", int'(bus_a.busy), 0);
    bus_a.req = 4'b0110;
    tick(1);
    rst_n = 1'b1;
    push(0, 4'b0010, 2, 1'b0, -1, 1);
    tick(2);
    bus_a.req = 4'b0000;
    tick(3);

    // TURNAROUND=3, MAX_HOLD=4 instance; a req[0] pulse inside the gap is lost.
    do_reset();
    push(1, 4'b0001, 4, 1'b1, -1, 0);
    push(1, 4'b0010, 4, 1'b1,  3, 1);
    bus_b.req = 4'b0011;
    tick(5);
    bus_b.req = 4'b0010;
    tick(7);
    bus_b.req = 4'b0001;
    tick(1);
    bus_b.req = 4'b0000;
    tick(3);
    check("dutb gnt after lost pulse", int'(bus_b.gnt), 0);
    check("dutb busy after lost pulse", int'(bus_b.busy), 0);

    tick(5);
    check("dut0 leftover expected runs", exp_q_a.size(), 0);
    check("dut1 leftover expected runs", exp_q_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
